// File: rtl/cpu_pkg.sv
// Shared constants for the boot path: RX FSM state encodings and default UART bit timing.
package cpu_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser; one-cycle valid 1 clk after the mid-stop sample.
// No backpressure: each byte is presented once and then lost.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err_pulse
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  rx_state_t        state;
  logic [BW-1:0]    bcnt;
  logic [IW-1:0]    idx;
  logic             rx_meta;
  logic             rxs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= RX_IDLE;
      bcnt            <= '0;
      idx             <= '0;
      data            <= '0;
      valid           <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      valid           <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            bcnt  <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (bcnt == HALF_BIT) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (!rxs) begin
              bcnt  <= '0;
              idx   <= '0;
              state <= RX_DATA;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bcnt == FULL_BIT) begin
            data[idx] <= rxs;
            bcnt      <= '0;
            if (idx == LAST_IDX) begin
              state <= RX_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bcnt == FULL_BIT) begin
            valid           <= rxs;
            frame_err_pulse <= !rxs;
            state           <= RX_IDLE;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a 2^ADDRESS_WIDTH-byte image from UART into program RAM, then releases the CPU from reset.
// mem_we rises 2 clk after the mid-stop-bit sample; no backpressure, RAM must accept every strobe.
module uart_boot_loader
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_data,
  output logic                     cpu_rstn,
  output logic                     load_done,
  output logic                     frame_err
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

  logic [WIDTH-1:0]         rx_data;
  logic                     rx_valid;
  logic                     rx_frame_err;
  logic [ADDRESS_WIDTH-1:0] count;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .WIDTH        (WIDTH)
  ) u_rx (
    .clk             (clk),
    .rstn            (rstn),
    .rx              (rx),
    .data            (rx_data),
    .valid           (rx_valid),
    .frame_err_pulse (rx_frame_err)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_rstn  <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
      count     <= '0;
    end else begin
      mem_we    <= 1'b0;
      frame_err <= frame_err | rx_frame_err;
      // Release the CPU the cycle after the final location is strobed.
      if (mem_we && mem_addr == LAST_ADDR) begin
        load_done <= 1'b1;
        cpu_rstn  <= 1'b1;
      end
      if (rx_valid && !load_done) begin
        mem_we   <= 1'b1;
        mem_addr <= count;
        mem_data <= rx_data;
        count    <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench: stimulus queues expected RAM writes, a negedge monitor checks each mem_we strobe.
module tb_uart_boot_loader;

  localparam int CPB = 8;
  localparam int W   = 8;
  localparam int AW  = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          cpu_rstn;
  logic          load_done;
  logic          frame_err;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic last_pending = 1'b0;
  logic prev_we = 1'b0;

  uart_boot_loader #(
    .CLKS_PER_BIT  (CPB),
    .WIDTH         (W),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_rstn  (cpu_rstn),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rstn) begin
      last_pending = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (last_pending) begin
        chk("release_after_last_write", {30'd0, cpu_rstn, load_done}, 32'h3);
        last_pending = 1'b0;
      end
      if (mem_we) begin
        chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
        chk("cpu_held_during_load", {30'd0, cpu_rstn, load_done}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {28'd0, mem_addr}, {28'd0, e.addr});
          chk("wr_data", {24'd0, mem_data}, {24'd0, e.data});
          if (e.addr == {AW{1'b1}}) last_pending = 1'b1;
        end
      end
      prev_we = mem_we;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int gap);
    logic [7:0] v;
    v = d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(stop_bit);
    @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (3 * CPB) @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
    chk("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Full load with idle gaps
    for (int i = 0; i < 16; i++) begin
      expect_wr(AW'(i), W'(8'h10 + i));
      send_byte(8'h10 + 8'(i), 1'b1, CPB);
    end
    drain("full_load_all_written");
    chk("full_load_done", {31'd0, load_done}, 32'd1);
    chk("full_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
    chk("full_frame_err", {31'd0, frame_err}, 32'd0);

    // Frame 17 after load: must not be written, outputs hold
    send_byte(8'hFF, 1'b1, CPB);
    drain("post_load_no_write");
    chk("post_load_addr_hold", {28'd0, mem_addr}, 32'hF);
    chk("post_load_data_hold", {24'd0, mem_data}, 32'h1F);
    chk("post_load_done_sticky", {31'd0, load_done}, 32'd1);

    // Frame error still flagged after load
    send_byte(8'h77, 1'b0, 2 * CPB);
    drain("post_load_fe_no_write");
    chk("post_load_frame_err", {31'd0, frame_err}, 32'd1);

    // Bad stop bit, then a good byte lands at the same address
    do_reset();
    chk("reset_clears_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_clears_load_done", {31'd0, load_done}, 32'd0);
    send_byte(8'hA5, 1'b0, 2 * CPB);
    chk("bad_stop_frame_err", {31'd0, frame_err}, 32'd1);
    expect_wr(4'h0, 8'h3C);
    send_byte(8'h3C, 1'b1, CPB);
    drain("after_fe_write");
    chk("frame_err_sticky", {31'd0, frame_err}, 32'd1);

    // Short glitch on rx is ignored
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_write", exp_q.size(), 32'd0);
    expect_wr(4'h0, 8'h5A);
    send_byte(8'h5A, 1'b1, CPB);
    drain("after_glitch_write");
    chk("glitch_no_frame_err", {31'd0, frame_err}, 32'd0);

    // Reset mid-byte 3, then back-to-back reload of 16 frames
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expect_wr(AW'(i), W'(8'h40 + i));
      send_byte(8'h40 + 8'(i), 1'b1, CPB);
    end
    drain("pre_abort_writes");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    repeat (2 * CPB) @(negedge clk);
    chk("abort_no_write", exp_q.size(), 32'd0);
    chk("abort_cpu_rstn_low", {31'd0, cpu_rstn}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      expect_wr(AW'(i), W'(8'h60 + 8'(i * 7)));
      send_byte(8'h60 + 8'(i * 7), 1'b1, 0);
    end
    drain("b2b_all_written");
    chk("b2b_load_done", {31'd0, load_done}, 32'd1);
    chk("b2b_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
    chk("b2b_frame_err", {31'd0, frame_err}, 32'd0);
    chk("b2b_last_addr", {28'd0, mem_addr}, 32'hF);
    chk("b2b_last_data", {24'd0, mem_data}, 32'hC9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
